alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Parametrised successor to the combinational ALU-control decode.
//   Decodes alu_op/funct into a 4-bit ALU control code, executes the operation on
//   WIDTH-bit operands and returns the result through valid/ready handshakes.
//   Adds an iterative multi-cycle MULT path. Sits in the EX stage between decode and writeback.
// PARAMETERS
//   WIDTH     32  operand/result width in bits (>=8)
//   ALU_OP_W  2   alu_op width; only bits [1:0] are decoded, upper bits ignored
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         request valid
//   in_ready   out  1         unit can accept a request this cycle
//   alu_op     in   ALU_OP_W  00=LW/SW add, 01=BEQ sub, 1x=R-type (use funct)
//   funct      in   6         R-type function code
//   a, b       in   WIDTH     operands
//   out_valid  out  1         result valid
//   out_ready  in   1         consumer takes result
//   result     out  WIDTH     registered result
//   zero       out  1         registered (result == 0)
//   alu_ctl    out  4         registered control code used for the result
//   illegal    out  1         registered: funct not recognised
//   busy       out  1         multiply in progress
// BEHAVIOUR
//   Decode: alu_op 00->ADD 0010; 01->SUB 0110; 1x: funct 100000 ADD 0010, 100010 SUB 0110,
//     100100 AND 0000, 100101 OR 0001, 101010 SLT 0111, 011000 MULT 1000, else ILLEGAL 1111.
//   ADD/SUB wrap modulo 2^WIDTH. SLT is signed: result = {WIDTH-1 zeros, $signed(a)<$signed(b)}.
//   MULT returns the low WIDTH bits of a*b. ILLEGAL returns result 0 and illegal=1.
//   FSM: IDLE, MUL. in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//   Single-cycle ops: result, zero, alu_ctl and illegal are registered on accept.
//     out_valid is set the next cycle (latency 1). Throughput is 1 per cycle while out_ready=1.
//   MULT: on accept, go IDLE->MUL. busy=1 for exactly WIDTH cycles (one shift-add step per cycle).
//     The result is registered on the last step, then return to IDLE with out_valid=1.
//     Latency is WIDTH+1 cycles. in_ready=0 throughout MUL; in_valid is ignored.
//   Output hold: while out_valid && !out_ready, result, zero, alu_ctl and illegal stay stable,
//     and in_ready=0.
//   Simultaneous events: an output handshake and a new accept in the same cycle are legal.
//     The new result replaces the old one and out_valid stays 1.
//   out_valid clears on handshake when nothing new is accepted.
//   Reset (async, any time, including mid-MULT): state=IDLE, out_valid=0, busy=0, result=0,
//     zero=0, alu_ctl=0000, illegal=0. A partial product is discarded and never emitted.
//     in_ready=1 on the first cycle after release.
// CONFIGURATION
//   ALU_NOR_EN defined: funct 100111 -> NOR, alu_ctl 1100, result = ~(a|b), latency 1.
//   ALU_NOR_EN undefined: funct 100111 decodes as ILLEGAL (1111, result 0, illegal=1).
// STRUCTURE
//   alu_pkg: alu_ctl_e enum (AND, OR, ADD, SUB, SLT, MUL, NOR, ILLEGAL), FUNCT_* constants,
//     ALU_OP_* constants, function alu_decode(alu_op, funct).
//   Sub-module alu_seq_mult #(WIDTH): iterative shift-add multiplier.
//     Ports: clk/rst_n/start/a/b -> done/product_lo.
//     done pulses after exactly WIDTH cycles. A start while not idle is impossible by construction.
// TESTING (WIDTH=32)
//   1. alu_op=00, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, alu_ctl=0010, zero=0.
//   2. alu_op=10, funct=101010: a=0xFFFFFFFF, b=1 -> result=1; a=1, b=0xFFFFFFFF -> result=0, zero=1.
//   3. MULT a=7, b=6 -> busy=1 and in_ready=0 for 32 cycles; out_valid at cycle 33 with result=42;
//      a=0x10000, b=0x10000 -> result=0, zero=1.
//   4. Back-to-back ADD, SUB, AND with out_ready=0 for 3 cycles: first result held, in_ready=0;
//      release -> results in order, one per cycle.
//   5. funct=000000 -> illegal=1, alu_ctl=1111, result=0;
//      funct=100111 -> NOR result (0xFFFFFFF0 for a=0x5, b=0xA) with ALU_NOR_EN, else illegal=1.
//   6. rst_n low 10 cycles into MULT -> out_valid=0, busy=0 immediately;
//      after release in_ready=1, and no stale product ever appears on out_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, FSM states, opcode/funct constants and decoder (ALU_NOR_EN adds NOR)
package alu_pkg;
  typedef enum logic [3:0] {
    CTL_AND     = 4'b0000,
    CTL_OR      = 4'b0001,
    CTL_ADD     = 4'b0010,
    CTL_SUB     = 4'b0110,
    CTL_SLT     = 4'b0111,
    CTL_MUL     = 4'b1000,
    CTL_NOR     = 4'b1100,
    CTL_ILLEGAL = 4'b1111
  } alu_ctl_e;
  typedef enum logic {ST_IDLE, ST_MUL} state_e;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
`ifdef ALU_NOR_EN
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
`endif
  function automatic alu_ctl_e alu_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == ALU_OP_ADD) return CTL_ADD;
    if (op == ALU_OP_SUB) return CTL_SUB;
    case (f)
      FUNCT_ADD: return CTL_ADD;
      FUNCT_SUB: return CTL_SUB;
      FUNCT_AND: return CTL_AND;
      FUNCT_OR:  return CTL_OR;
      FUNCT_SLT: return CTL_SLT;
      FUNCT_MUL: return CTL_MUL;
`ifdef ALU_NOR_EN
      FUNCT_NOR: return CTL_NOR;
`endif
      default:   return CTL_ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq_mult.sv
// alu_seq_mult: iterative shift-add multiplier, one partial product per cycle, done on the last step
module alu_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  // the final step's sum is exposed combinationally so the caller can register it with done
  assign product_lo = acc + (mplier[0] ? mcand : '0);
  assign done = running && cnt == LAST;
  // load operands on start, then add-and-shift once per cycle until the last step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      running <= !done;
      cnt     <= cnt + 1'b1;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      acc     <= product_lo;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decode alu_op/funct, execute with valid/ready handshakes, multi-cycle MULT (ALU_NOR_EN adds NOR)
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [5:0]          funct,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic [3:0]          alu_ctl,
  output logic                illegal,
  output logic                busy
);
  state_e           state, state_nx;
  alu_ctl_e         ctl;
  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] alu_res, mul_res;
  assign ctl       = alu_decode(alu_op[1:0], funct);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && ctl == CTL_MUL;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // next state: enter MUL on a multiply accept, leave on the multiplier's last step
  always_comb
    state_nx = state == ST_IDLE ? (mul_start ? ST_MUL : ST_IDLE) : (mul_done ? ST_IDLE : ST_MUL);
  // FSM outputs: accept only when idle and the output slot is free or draining
  always_comb begin
    in_ready = state == ST_IDLE && (!out_valid || out_ready);
    busy     = state == ST_MUL;
  end
  alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .a          (a),
    .b          (b),
    .done       (mul_done),
    .product_lo (mul_res)
  );
  // single-cycle operations; ILLEGAL and MUL fall through to zero
  always_comb
    alu_res = ctl == CTL_ADD ? a + b :
              ctl == CTL_SUB ? a - b :
              ctl == CTL_AND ? a & b :
              ctl == CTL_OR  ? a | b :
              ctl == CTL_SLT ? WIDTH'($signed(a) < $signed(b)) :
              ctl == CTL_NOR ? ~(a | b) : '0;
  // output register: load on single-cycle accept or multiply completion, clear on drain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      alu_ctl   <= 4'b0000;
      illegal   <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= alu_res == '0;
      alu_ctl   <= ctl;
      illegal   <= ctl == CTL_ILLEGAL;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_res;
      zero      <= mul_res == '0;
      alu_ctl   <= CTL_MUL;
      illegal   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a cycle-level model (ALU_NOR_EN aware)
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b, result;
  logic        zero, illegal, busy;
  logic [3:0]  alu_ctl;
  int checks = 0;
  int errors = 0;
  logic        rnd = 1'b0;
  logic        mvalid = 1'b0;
  logic [31:0] mres, pres;
  logic [3:0]  mctl;
  int          mul_left = 0;
  logic [5:0]  fl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h27, 6'h00};
  logic [31:0] corner [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1};

  alu_exec_unit #(.WIDTH(32), .ALU_OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .alu_ctl(alu_ctl), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] c);
    logic [63:0] p;
    p = {32'h0, x} * {32'h0, y};
    c = 4'hF;
    r = 32'h0;
    if (op == 2'b00) begin c = 4'h2; r = x + y; end
    else if (op == 2'b01) begin c = 4'h6; r = x - y; end
    else
      case (f)
        6'h20: begin c = 4'h2; r = x + y; end
        6'h22: begin c = 4'h6; r = x - y; end
        6'h24: begin c = 4'h0; r = x & y; end
        6'h25: begin c = 4'h1; r = x | y; end
        6'h2A: begin c = 4'h7; r = ($signed(x) < $signed(y)) ? 32'h1 : 32'h0; end
        6'h18: begin c = 4'h8; r = 32'(p); end
`ifdef ALU_NOR_EN
        6'h27: begin c = 4'hC; r = ~(x | y); end
`endif
        default: ;
      endcase
  endfunction

  // cycle-level reference: check this cycle's outputs, then advance by the coming edge
  always @(negedge clk) begin
    logic exp_busy, exp_ready, hs, acc;
    logic [31:0] r;
    logic [3:0] c;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_alu_ctl", alu_ctl, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_zero", zero, 0);
      mvalid = 1'b0;
      mul_left = 0;
    end else begin
      exp_busy  = mul_left != 0;
      exp_ready = !exp_busy && (!mvalid || out_ready);
      chk("out_valid", out_valid, mvalid);
      chk("busy", busy, exp_busy);
      chk("in_ready", in_ready, exp_ready);
      if (mvalid) begin
        chk("result", result, mres);
        chk("alu_ctl", alu_ctl, mctl);
        chk("illegal", illegal, mctl == 4'hF);
        chk("zero", zero, mres == 0);
      end
      hs  = mvalid && out_ready;
      acc = in_valid && exp_ready;
      if (mul_left != 0) begin
        mul_left--;
        if (mul_left == 0) begin mvalid = 1'b1; mres = pres; mctl = 4'h8; end
      end else if (acc) begin
        ref_op(alu_op, funct, a, b, r, c);
        if (c == 4'h8) begin
          mul_left = 32;
          pres = r;
          if (hs) mvalid = 1'b0;
        end else begin
          mvalid = 1'b1; mres = r; mctl = c;
        end
      end else if (hs) mvalid = 1'b0;
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    bit ok = 0;
    in_valid = 1'b1; alu_op = op; funct = f; a = x; b = y;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #2;
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
    end
    if (ok) begin
      @(posedge clk); #2;
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stayed 0, required 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic get(output logic [31:0] r, output logic [3:0] c, output logic il, output logic z,
                     output int lat, output int busy_n, output int nrdy_n);
    lat = 0; busy_n = 0; nrdy_n = 0; r = '0; c = '0; il = 0; z = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (out_valid) begin r = result; c = alu_ctl; il = illegal; z = zero; lat = n + 1; break; end
      busy_n += int'(busy);
      nrdy_n += int'(!in_ready);
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL get_timeout out_valid stayed 0, required 1 within 60 cycles");
    end
    @(posedge clk); #2;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0] c;
    logic il, z;
    int lat, bn, nr, seen;
    logic [1:0] op;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk); #2;
    send(2'b00, 6'h00, 32'd5, 32'd7);
    get(r, c, il, z, lat, bn, nr);
    chk("add_result", r, 12); chk("add_ctl", c, 4'b0010); chk("add_zero", z, 0); chk("add_lat", lat, 1);
    send(2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1);
    get(r, c, il, z, lat, bn, nr);
    chk("slt_neg_result", r, 1); chk("slt_ctl", c, 4'b0111);
    send(2'b10, 6'h2A, 32'd1, 32'hFFFFFFFF);
    get(r, c, il, z, lat, bn, nr);
    chk("slt_pos_result", r, 0); chk("slt_pos_zero", z, 1);
    send(2'b10, 6'h18, 32'd7, 32'd6);
    get(r, c, il, z, lat, bn, nr);
    chk("mul_result", r, 42); chk("mul_ctl", c, 4'b1000); chk("mul_lat", lat, 33);
    chk("mul_busy_cycles", bn, 32); chk("mul_noready_cycles", nr, 32);
    send(2'b11, 6'h18, 32'h10000, 32'h10000);
    get(r, c, il, z, lat, bn, nr);
    chk("mul_wrap_result", r, 0); chk("mul_wrap_zero", z, 1);
    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'd10, 32'd3);
    in_valid = 1'b1; alu_op = 2'b01; a = 32'd10; b = 32'd3;
    repeat (3) begin
      @(negedge clk); #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, 13);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    send(2'b01, 6'h00, 32'd10, 32'd3);
    #1 chk("b2b_sub_result", result, 7);
    send(2'b10, 6'h24, 32'd12, 32'd10);
    get(r, c, il, z, lat, bn, nr);
    chk("b2b_and_result", r, 8); chk("b2b_and_lat", lat, 1);
    send(2'b10, 6'h00, 32'd9, 32'd9);
    get(r, c, il, z, lat, bn, nr);
    chk("illegal_flag", il, 1); chk("illegal_ctl", c, 4'b1111); chk("illegal_result", r, 0);
    send(2'b10, 6'h27, 32'h5, 32'hA);
    get(r, c, il, z, lat, bn, nr);
`ifdef ALU_NOR_EN
    chk("nor_result", r, 32'hFFFFFFF0); chk("nor_ctl", c, 4'b1100); chk("nor_illegal", il, 0);
`else
    chk("nor_off_result", r, 0); chk("nor_off_ctl", c, 4'b1111); chk("nor_off_illegal", il, 1);
`endif
    send(2'b10, 6'h18, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #2 chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_midmul_reset", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      seen += int'(out_valid);
    end
    chk("no_stale_product", seen, 0);
    @(posedge clk); #2;
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9) == 0 ? 2'b00 : $urandom_range(0, 9) == 0 ? 2'b01 : {1'b1, 1'($urandom)};
      send(op, $urandom_range(0, 7) == 0 ? 6'($urandom) : fl[$urandom_range(0, 7)],
           $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : $urandom,
           $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
        out_ready = $urandom_range(0, 3) != 0;
      end
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
